instr_fetch_unit: RTL and testbench

//  Front end of the RV32 core, directly upstream of decode. Owns the program counter, fetches 32-bit words from

---
 rtl/rv_fetch_pkg.sv | 18 +
 rtl/instr_fetch_unit_queue.sv | 55 +++++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch front end.
package rv_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// fetch_queue: synchronous FIFO of fetch entries with push, pop, flush, count and full/empty.
module fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 fetch front end: PC, imem req/ack fetch FSM, fetch queue toward decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises sticky fetch_fault and halts fetch.
module instr_fetch_unit #(
  parameter int unsigned           XLEN        = rv_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]       RESET_PC    = rv_fetch_pkg::RESET_PC_DEFAULT,
  parameter int unsigned           QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_fault
);

  import rv_fetch_pkg::*;

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    state_nx;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] drop_addr;
  logic            fault;

  logic            push;
  logic            pop;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   cnt_after;
  fetch_entry_t    q_head;
  fetch_entry_t    q_wdata;

  assign push     = (state == REQ) && imem_ack && !redirect_valid;
  assign pop      = instr_valid && instr_ready && !redirect_valid;
  assign q_wdata  = '{instr: imem_rdata, pc: pc};
  // occupancy once this cycle's ack lands and any pop retires
  assign cnt_after = q_count + CW'(1) - CW'(pop);

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (q_wdata),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (!redirect_valid && !fault && (!q_full || pop)) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          state_nx = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          state_nx = (cnt_after < CW'(QUEUE_DEPTH)) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // DROP keeps presenting the killed address until its ack retires the request
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      state <= state_nx;
      if (redirect_valid) begin
        pc <= redirect_pc & ~XLEN'(3);
      end else if (push) begin
        pc <= pc + XLEN'(4);
      end
      if (redirect_valid && (state == REQ)) begin
        drop_addr <= pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (redirect_valid) begin
      fault <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign fault = 1'b0;
`endif

  assign imem_req    = (state != IDLE);
  assign imem_addr   = (state == DROP) ? drop_addr : pc;
  assign instr_valid = !q_empty;
  assign instr_out   = q_empty ? '0 : q_head.instr;
  assign instr_pc    = q_empty ? '0 : q_head.pc;
  assign fetch_fault = fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic against a stream model.
module tb_instr_fetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr_out;
  logic [XLEN-1:0] instr_pc;
  logic            fetch_fault;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .XLEN        (XLEN),
    .RESET_PC    (32'h0),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // memory responder state
  int unsigned lat_min, lat_max, mem_wait, ack_count;
  bit          mem_new;
  logic [31:0] mem_addr;

  // stream model: after reset/redirect, deliveries are target, target+4, ... with word = mem_word(pc)
  logic [31:0] exp_pc;
  bit          exp_fault;
  int unsigned delivered;
  logic [31:0] last_pc;
  bit          flush_seen, hold_seen;
  logic [31:0] hold_pc, hold_instr;

  task automatic mem_drive();
    if (rst) begin
      imem_ack = 1'b0;
      mem_new  = 1'b1;
      return;
    end
    if (imem_ack) begin
      imem_ack = 1'b0;
      mem_new  = 1'b1;
    end
    if (imem_req) begin
      if (mem_new) begin
        mem_new  = 1'b0;
        mem_addr = imem_addr;
        mem_wait = $urandom_range(lat_max, lat_min);
        check_eq("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
      end else begin
        check_eq("addr_stable", imem_addr, mem_addr);
      end
      if (mem_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        ack_count++;
      end else begin
        mem_wait--;
      end
    end else if (!mem_new) begin
      check_eq("req_held", {31'b0, imem_req}, 32'h1);
    end
  endtask

  task automatic score();
    flush_seen = 1'b0;
    hold_seen  = 1'b0;
    if (rst) begin
      exp_pc    = 32'h0;
      exp_fault = 1'b0;
      return;
    end
    if (redirect_valid) begin
      exp_pc     = redirect_pc & ~32'h3;
      flush_seen = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_fault  = (redirect_pc[1:0] != 2'b00);
`endif
    end else if (instr_valid) begin
      if (instr_ready) begin
        check_eq("deliver_pc", instr_pc, exp_pc);
        check_eq("deliver_instr", instr_out, mem_word(exp_pc));
        last_pc = instr_pc;
        exp_pc  = exp_pc + 32'd4;
        delivered++;
      end else begin
        hold_seen  = 1'b1;
        hold_pc    = instr_pc;
        hold_instr = instr_out;
      end
    end
  endtask

  task automatic post();
    check_eq("fault", {31'b0, fetch_fault}, {31'b0, exp_fault});
    if (flush_seen) check_eq("flush_empty", {31'b0, instr_valid}, 32'h0);
    if (hold_seen) begin
      check_eq("hold_valid", {31'b0, instr_valid}, 32'h1);
      check_eq("hold_pc", instr_pc, hold_pc);
      check_eq("hold_instr", instr_out, hold_instr);
    end
  endtask

  // inputs for this cycle are already set; model the coming posedge, then sample at the next negedge
  task automatic cycle();
    mem_drive();
    score();
    @(negedge clk);
    post();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic wait_delivery(input string tag, input int unsigned budget);
    int unsigned d0 = delivered;
    int unsigned n  = 0;
    while (delivered == d0 && n < budget) begin
      cycle();
      n++;
    end
    check_eq(tag, {31'b0, delivered != d0}, 32'h1);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned d0;
    int unsigned n;
    rst            = 1'b1;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    lat_min        = 0;
    lat_max        = 0;
    mem_new        = 1'b1;
    delivered      = 0;
    ack_count      = 0;
    last_pc        = '0;
    @(negedge clk);
    repeat (3) cycle();
    check_eq("rst_req", {31'b0, imem_req}, 32'h0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("rst_instr", instr_out, 32'h0);
    check_eq("rst_pc", instr_pc, 32'h0);

    // zero-wait memory, ready=1: first request one cycle after reset, one instr per cycle
    rst = 1'b0;
    instr_ready = 1'b1;
    cycle();
    check_eq("t1_req_c1", {31'b0, imem_req}, 32'h1);
    check_eq("t1_novalid_c1", {31'b0, instr_valid}, 32'h0);
    cycle();
    check_eq("t1_valid_c2", {31'b0, instr_valid}, 32'h1);
    check_eq("t1_pc_c2", instr_pc, 32'h0);
    for (int unsigned i = 1; i <= 3; i++) begin
      cycle();
      check_eq("t1_stream_valid", {31'b0, instr_valid}, 32'h1);
      check_eq("t1_stream_pc", instr_pc, 32'(4 * i));
    end

    // backpressure: queue fills, requests stop, head holds
    do_reset();
    ack_count   = 0;
    instr_ready = 1'b0;
    repeat (10) cycle();
    check_eq("t2_full_valid", {31'b0, instr_valid}, 32'h1);
    check_eq("t2_head_pc", instr_pc, 32'h0);
    check_eq("t2_req_low", {31'b0, imem_req}, 32'h0);
    check_eq("t2_fetched", ack_count, DEPTH);
    d0 = delivered;
    instr_ready = 1'b1;
    repeat (10) cycle();
    check_eq("t2_resume", {31'b0, (delivered - d0) >= 8}, 32'h1);

    // redirect while a slow request is outstanding
    lat_min = 3;
    lat_max = 3;
    do_reset();
    instr_ready = 1'b1;
    n = 0;
    while (!imem_req && n < 10) begin
      cycle();
      n++;
    end
    check_eq("t3_req_seen", {31'b0, imem_req}, 32'h1);
    redirect_to(32'h100);
    check_eq("t3_drop_req", {31'b0, imem_req}, 32'h1);
    check_eq("t3_drop_addr", imem_addr, 32'h0);
    wait_delivery("t3_delivery", 30);
    check_eq("t3_first_pc", last_pc, 32'h100);

    // redirect coinciding with ack and pop
    lat_min = 0;
    lat_max = 0;
    n = 0;
    while (!(imem_req && instr_valid) && n < 10) begin
      cycle();
      n++;
    end
    check_eq("t4_busy", {31'b0, imem_req && instr_valid}, 32'h1);
    redirect_to(32'h300);
    check_eq("t4_idle", {31'b0, imem_req}, 32'h0);
    cycle();
    check_eq("t4_req", {31'b0, imem_req}, 32'h1);
    check_eq("t4_addr", imem_addr, 32'h300);
    wait_delivery("t4_delivery", 10);
    check_eq("t4_first_pc", last_pc, 32'h300);

    // PC wrap
    redirect_to(32'hFFFF_FFF8);
    wait_delivery("t5_d0", 10);
    check_eq("t5_pc0", last_pc, 32'hFFFF_FFF8);
    wait_delivery("t5_d1", 10);
    check_eq("t5_pc1", last_pc, 32'hFFFF_FFFC);
    wait_delivery("t5_d2", 10);
    check_eq("t5_pc2", last_pc, 32'h0);

    // misaligned redirect
`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_to(32'h102);
    for (int unsigned i = 0; i < 5; i++) begin
      cycle();
      check_eq("t6_no_req", {31'b0, imem_req}, 32'h0);
      check_eq("t6_fault", {31'b0, fetch_fault}, 32'h1);
    end
    redirect_to(32'h200);
    wait_delivery("t6_delivery", 10);
    check_eq("t6_resume_pc", last_pc, 32'h200);
    check_eq("t6_fault_clr", {31'b0, fetch_fault}, 32'h0);
`else
    redirect_to(32'h102);
    wait_delivery("t6_delivery", 10);
    check_eq("t6_aligned_pc", last_pc, 32'h100);
    check_eq("t6_no_fault", {31'b0, fetch_fault}, 32'h0);
`endif

    // randomized traffic
    lat_min = 0;
    lat_max = 3;
    d0 = delivered;
    for (int unsigned i = 0; i < 3000; i++) begin
      instr_ready    = ($urandom_range(99, 0) < 70);
      redirect_valid = ($urandom_range(99, 0) < 3);
      if ($urandom_range(99, 0) < 20) begin
        redirect_pc = 32'hFFFF_FFF0 + ($urandom_range(3, 0) << 2);
      end else begin
        redirect_pc = $urandom & ~32'h3;
      end
      cycle();
    end
    redirect_valid = 1'b0;
    check_eq("rand_progress", {31'b0, (delivered - d0) > 300}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
